// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared types and defaults for the two-master I2C driver arbiter.
package i2c_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT0  = 2'd1,
    GRANT1  = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 2_000_000;
  localparam int DEFAULT_CTR_SIZE       = 21;

  typedef struct packed {
    logic       ena;
    logic       rw;
    logic       start_transfer;
    logic       stop_transfer;
    logic       r_start;
    logic [7:0] data_wr;
  } cmd_t;

  typedef struct packed {
    logic       busy;
    logic       ready;
    logic       ack_err;
    logic [7:0] data_rd;
  } status_t;

endpackage

// File: rtl/i2c_bus_arbiter_cmd_mux.sv
// Combinational steering of command and status buses by a one-hot grant vector.
module i2c_cmd_mux
  import i2c_bus_arbiter_pkg::*;
(
  input  logic [1:0] gnt,
  input  cmd_t       cmd0,
  input  cmd_t       cmd1,
  input  status_t    drv_status,
  input  logic [7:0] hold_rd0,
  input  logic [7:0] hold_rd1,
  output cmd_t       drv_cmd,
  output status_t    status0,
  output status_t    status1
);

  // A requester without the grant sees a permanently busy driver.
  always_comb begin
    drv_cmd = '0;
    status0 = '{busy: 1'b1, ready: 1'b0, ack_err: 1'b0, data_rd: hold_rd0};
    status1 = '{busy: 1'b1, ready: 1'b0, ack_err: 1'b0, data_rd: hold_rd1};
    case (gnt)
      2'b01: begin
        drv_cmd = cmd0;
        status0 = drv_status;
      end
      2'b10: begin
        drv_cmd = cmd1;
        status1 = drv_status;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin, transaction-granular arbiter sharing one I2C driver between two masters,
// with a watchdog that revokes an over-long grant.
//
//   state   | meaning
//   IDLE    | no grant; arbitration between pending requests
//   GRANT0  | requester 0 owns the driver
//   GRANT1  | requester 1 owns the driver
//   RELEASE | commands forced idle until the driver reports ready
module i2c_bus_arbiter
  import i2c_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CTR_SIZE       = DEFAULT_CTR_SIZE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  output logic       gnt0,
  output logic       gnt1,
  input  logic       ena0,
  input  logic       ena1,
  input  logic       rw0,
  input  logic       rw1,
  input  logic       start_transfer0,
  input  logic       start_transfer1,
  input  logic       stop_transfer0,
  input  logic       stop_transfer1,
  input  logic       r_start0,
  input  logic       r_start1,
  input  logic [7:0] data_wr0,
  input  logic [7:0] data_wr1,
  output logic [7:0] data_rd0,
  output logic [7:0] data_rd1,
  output logic       busy0,
  output logic       busy1,
  output logic       ready0,
  output logic       ready1,
  output logic       ack_err0,
  output logic       ack_err1,
  output logic       drv_ena,
  output logic       drv_rw,
  output logic       drv_start_transfer,
  output logic       drv_stop_transfer,
  output logic       drv_r_start,
  output logic [7:0] drv_data_wr,
  input  logic [7:0] drv_data_rd,
  input  logic       drv_busy,
  input  logic       drv_ready,
  input  logic       drv_ack_err,
  output logic       timeout
);

  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam int WD_LAST_I = WD_EN ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CTR_SIZE-1:0] WD_LAST = CTR_SIZE'(WD_LAST_I);

  arb_state_t          state, state_next;
  logic                last, last_next;
  logic [CTR_SIZE-1:0] wd_cnt;
  logic [1:0]          revoked;
  logic [7:0]          hold_rd0, hold_rd1;
  logic                eff_req0, eff_req1, wd_expire;

  cmd_t    cmd0, cmd1, drv_cmd;
  status_t drv_status, status0, status1;

  assign gnt0 = (state == GRANT0);
  assign gnt1 = (state == GRANT1);

  // A revoked requester must drop req before it may compete again.
  assign eff_req0  = req0 && !revoked[0];
  assign eff_req1  = req1 && !revoked[1];
  assign wd_expire = WD_EN && (wd_cnt == WD_LAST);

  always_comb begin
    state_next = state;
    last_next  = last;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (eff_req0 && eff_req1) state_next = last ? GRANT0 : GRANT1;
        else if (eff_req0)        state_next = GRANT0;
        else if (eff_req1)        state_next = GRANT1;
      end
      GRANT0: begin
        if (!req0) state_next = RELEASE;
        else if (wd_expire) begin
          state_next = RELEASE;
          timeout    = 1'b1;
        end
      end
      GRANT1: begin
        if (!req1) state_next = RELEASE;
        else if (wd_expire) begin
          state_next = RELEASE;
          timeout    = 1'b1;
        end
      end
      RELEASE: begin
        if (!drv_busy && drv_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (state == IDLE && state_next == GRANT0) last_next = 1'b0;
    if (state == IDLE && state_next == GRANT1) last_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      wd_cnt   <= '0;
      revoked  <= 2'b00;
      hold_rd0 <= 8'h00;
      hold_rd1 <= 8'h00;
    end else begin
      state <= state_next;
      last  <= last_next;

      if (state == IDLE && state_next != IDLE)  wd_cnt <= '0;
      else if ((gnt0 || gnt1) && wd_cnt != '1)  wd_cnt <= wd_cnt + 1'b1;

      if (!req0)                   revoked[0] <= 1'b0;
      else if (timeout && gnt0)    revoked[0] <= 1'b1;
      if (!req1)                   revoked[1] <= 1'b0;
      else if (timeout && gnt1)    revoked[1] <= 1'b1;

      if (gnt0) hold_rd0 <= drv_data_rd;
      if (gnt1) hold_rd1 <= drv_data_rd;
    end
  end

  assign cmd0 = {ena0, rw0, start_transfer0, stop_transfer0, r_start0, data_wr0};
  assign cmd1 = {ena1, rw1, start_transfer1, stop_transfer1, r_start1, data_wr1};
  assign drv_status = {drv_busy, drv_ready, drv_ack_err, drv_data_rd};

  i2c_cmd_mux u_cmd_mux (
    .gnt        ({gnt1, gnt0}),
    .cmd0       (cmd0),
    .cmd1       (cmd1),
    .drv_status (drv_status),
    .hold_rd0   (hold_rd0),
    .hold_rd1   (hold_rd1),
    .drv_cmd    (drv_cmd),
    .status0    (status0),
    .status1    (status1)
  );

  assign drv_ena            = drv_cmd.ena;
  assign drv_rw             = drv_cmd.rw;
  assign drv_start_transfer = drv_cmd.start_transfer;
  assign drv_stop_transfer  = drv_cmd.stop_transfer;
  assign drv_r_start        = drv_cmd.r_start;
  assign drv_data_wr        = drv_cmd.data_wr;

  assign busy0    = status0.busy;
  assign ready0   = status0.ready;
  assign ack_err0 = status0.ack_err;
  assign data_rd0 = status0.data_rd;
  assign busy1    = status1.busy;
  assign ready1   = status1.ready;
  assign ack_err1 = status1.ack_err;
  assign data_rd1 = status1.data_rd;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter: vector table during a grant plus hand-written
// sequences for release, alternation, watchdog revocation and reset.
module tb_i2c_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, gnt0, gnt1;
  logic       ena0, ena1, rw0, rw1, start_transfer0, start_transfer1;
  logic       stop_transfer0, stop_transfer1, r_start0, r_start1;
  logic [7:0] data_wr0, data_wr1, data_rd0, data_rd1;
  logic       busy0, busy1, ready0, ready1, ack_err0, ack_err1;
  logic       drv_ena, drv_rw, drv_start_transfer, drv_stop_transfer, drv_r_start;
  logic [7:0] drv_data_wr, drv_data_rd;
  logic       drv_busy, drv_ready, drv_ack_err, timeout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  i2c_bus_arbiter #(.TIMEOUT_CYCLES(100), .CTR_SIZE(21)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .ena0(ena0), .ena1(ena1), .rw0(rw0), .rw1(rw1),
    .start_transfer0(start_transfer0), .start_transfer1(start_transfer1),
    .stop_transfer0(stop_transfer0), .stop_transfer1(stop_transfer1),
    .r_start0(r_start0), .r_start1(r_start1),
    .data_wr0(data_wr0), .data_wr1(data_wr1), .data_rd0(data_rd0), .data_rd1(data_rd1),
    .busy0(busy0), .busy1(busy1), .ready0(ready0), .ready1(ready1),
    .ack_err0(ack_err0), .ack_err1(ack_err1),
    .drv_ena(drv_ena), .drv_rw(drv_rw), .drv_start_transfer(drv_start_transfer),
    .drv_stop_transfer(drv_stop_transfer), .drv_r_start(drv_r_start),
    .drv_data_wr(drv_data_wr), .drv_data_rd(drv_data_rd),
    .drv_busy(drv_busy), .drv_ready(drv_ready), .drv_ack_err(drv_ack_err),
    .timeout(timeout)
  );

  typedef struct {
    logic [4:0] c0;     // {ena, rw, start, stop, r_start}
    logic [7:0] w0;
    logic [4:0] c1;
    logic [7:0] w1;
    logic [2:0] st;     // {busy, ready, ack_err} from driver
    logic [7:0] rd;
    logic [4:0] e_cmd;
    logic [7:0] e_wr;
    logic [2:0] e_st0;
    logic [7:0] e_rd0;
    logic [2:0] e_st1;
    logic [7:0] e_rd1;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin
    int bad;
    int n;
    int got;

    // Requester 0 owns the bus; requester 1 commands must never reach the driver.
    vecs[0] = '{5'b10000, 8'h12, 5'b11111, 8'hA5, 3'b100, 8'h00,
                5'b10000, 8'h12, 3'b100, 8'h00, 3'b100, 8'h00};
    vecs[1] = '{5'b11000, 8'h34, 5'b10000, 8'hA5, 3'b100, 8'h5A,
                5'b11000, 8'h34, 3'b100, 8'h5A, 3'b100, 8'h00};
    vecs[2] = '{5'b10100, 8'h56, 5'b00000, 8'hFF, 3'b110, 8'h77,
                5'b10100, 8'h56, 3'b110, 8'h77, 3'b100, 8'h00};
    vecs[3] = '{5'b10010, 8'h78, 5'b11111, 8'hA5, 3'b111, 8'h77,
                5'b10010, 8'h78, 3'b111, 8'h77, 3'b100, 8'h00};
    vecs[4] = '{5'b10001, 8'h9A, 5'b10000, 8'hA5, 3'b010, 8'h3C,
                5'b10001, 8'h9A, 3'b010, 8'h3C, 3'b100, 8'h00};
    vecs[5] = '{5'b10000, 8'hBC, 5'b01010, 8'h00, 3'b100, 8'h3C,
                5'b10000, 8'hBC, 3'b100, 8'h3C, 3'b100, 8'h00};

    rst = 1'b1; req0 = 0; req1 = 0;
    {ena0, rw0, start_transfer0, stop_transfer0, r_start0} = '0;
    {ena1, rw1, start_transfer1, stop_transfer1, r_start1} = '0;
    data_wr0 = 8'h00; data_wr1 = 8'h00;
    drv_data_rd = 8'h00; drv_busy = 1'b0; drv_ready = 1'b1; drv_ack_err = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_gnt", {gnt1, gnt0}, 2'b00);
    chk("reset_timeout", timeout, 1'b0);
    chk("reset_drv_ena", drv_ena, 1'b0);
    chk("reset_data_rd", {data_rd1, data_rd0}, 16'h0000);
    chk("reset_status", {busy0, ready0, ack_err0, busy1, ready1, ack_err1}, 6'b100100);
    rst = 1'b0;

    // Single requester: 1-cycle grant latency, ena without grant is ignored.
    @(negedge clk);
    req0 = 1'b1; ena0 = 1'b1; data_wr0 = 8'h12;
    #1;
    chk("a_gnt_latency", gnt0, 1'b0);
    chk("a_ena_no_gnt", drv_ena, 1'b0);
    @(negedge clk);
    chk("a_gnt0", {gnt1, gnt0}, 2'b01);
    chk("a_drv_ena", drv_ena, 1'b1);
    drv_busy = 1'b1;

    foreach (vecs[i]) begin
      {ena0, rw0, start_transfer0, stop_transfer0, r_start0} = vecs[i].c0;
      data_wr0 = vecs[i].w0;
      {ena1, rw1, start_transfer1, stop_transfer1, r_start1} = vecs[i].c1;
      data_wr1 = vecs[i].w1;
      {drv_busy, drv_ready, drv_ack_err} = vecs[i].st;
      drv_data_rd = vecs[i].rd;
      #1;
      chk($sformatf("v%0d_cmd", i),
          {drv_ena, drv_rw, drv_start_transfer, drv_stop_transfer, drv_r_start}, vecs[i].e_cmd);
      chk($sformatf("v%0d_wr", i), drv_data_wr, vecs[i].e_wr);
      chk($sformatf("v%0d_st0", i), {busy0, ready0, ack_err0}, vecs[i].e_st0);
      chk($sformatf("v%0d_rd0", i), data_rd0, vecs[i].e_rd0);
      chk($sformatf("v%0d_st1", i), {busy1, ready1, ack_err1}, vecs[i].e_st1);
      chk($sformatf("v%0d_rd1", i), data_rd1, vecs[i].e_rd1);
      @(negedge clk);
    end

    {ena1, rw1, start_transfer1, stop_transfer1, r_start1} = '0;
    drv_busy = 1'b1; drv_ready = 1'b1; drv_ack_err = 1'b0;
    bad = 0;
    for (int k = 7; k <= 50; k++) begin
      if (gnt1 || !gnt0 || timeout) bad++;
      @(negedge clk);
    end
    chk("a_hold_window_bad", bad, 0);

    // Release waits for the driver, then one IDLE cycle before the next grant.
    req0 = 1'b0;
    @(negedge clk);
    drv_data_rd = 8'hEE; req1 = 1'b1;
    #1;
    chk("a_release_gnt", {gnt1, gnt0}, 2'b00);
    chk("a_release_ena", drv_ena, 1'b0);
    chk("a_release_rd0_hold", data_rd0, 8'h3C);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (gnt1 || gnt0) bad++;
    end
    chk("a_release_wait_bad", bad, 0);
    drv_busy = 1'b0;
    @(negedge clk);
    chk("a_idle_gap", gnt1, 1'b0);
    @(negedge clk);
    chk("a_gnt1", {gnt1, gnt0}, 2'b10);
    chk("a_rd1_live", data_rd1, 8'hEE);
    chk("a_rd0_hold", data_rd0, 8'h3C);

    // Synchronous reset in the middle of a GRANT1 transaction.
    ena1 = 1'b1; drv_busy = 1'b1;
    #1;
    chk("e_pre_rst_ena", drv_ena, 1'b1);
    rst = 1'b1; req1 = 1'b0;
    @(negedge clk);
    chk("e_rst_gnt", {gnt1, gnt0}, 2'b00);
    chk("e_rst_ena", drv_ena, 1'b0);
    chk("e_rst_timeout", timeout, 1'b0);
    chk("e_rst_rd1", data_rd1, 8'h00);
    rst = 1'b0; drv_busy = 1'b0; ena1 = 1'b0; ena0 = 1'b0;
    @(negedge clk);

    // Both requesters re-raising every transaction: strict alternation 0,1,0,1.
    req0 = 1'b1; req1 = 1'b1;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (!(gnt0 || gnt1) && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("b_grant%0d_wait", g), (n < 10), 1'b1);
      chk($sformatf("b_grant%0d_onehot", g), {gnt1, gnt0}, (g % 2 == 0) ? 2'b01 : 2'b10);
      got = gnt1 ? 1 : 0;
      repeat (3) @(negedge clk);
      if (got == 0) req0 = 1'b0; else req1 = 1'b0;
      @(negedge clk);
      if (got == 0) req0 = 1'b1; else req1 = 1'b1;
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);

    // Watchdog: req1 held forever is revoked at grant-cycle 100.
    req1 = 1'b1;
    @(negedge clk);
    chk("d_gnt1", {gnt1, gnt0}, 2'b10);
    req0 = 1'b1;
    bad = 0;
    for (int k = 1; k <= 100; k++) begin
      if (timeout !== (k == 100)) bad++;
      if (!gnt1) bad++;
      if (k == 100) chk("d_timeout_pulse", timeout, 1'b1);
      else @(negedge clk);
    end
    chk("d_grant_window_bad", bad, 0);
    @(negedge clk);
    chk("d_revoked_gnt", {gnt1, gnt0}, 2'b00);
    chk("d_timeout_one_cycle", timeout, 1'b0);
    @(negedge clk);
    chk("d_idle_gap", gnt0, 1'b0);
    @(negedge clk);
    chk("d_pending_gnt0", {gnt1, gnt0}, 2'b01);
    req0 = 1'b0;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (gnt1) bad++;
    end
    chk("d_no_regrant_bad", bad, 0);
    req1 = 1'b0;
    @(negedge clk);
    req1 = 1'b1;
    @(negedge clk);
    chk("d_regrant_after_drop", {gnt1, gnt0}, 2'b10);
    req1 = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
Shares one I2C_Driver instance between two I2C master controllers, for example the altimeter and IMU controllers on a common bus.
- Grants the driver at transaction granularity, from request until release, using round-robin arbitration.
- Muxes each controller's command signals onto the driver and routes driver status back to the granted controller only.
- A watchdog reclaims the bus from a requester that holds it too long.

Parameters:
TIMEOUT_CYCLES, 2_000_000, max cycles one grant may be held (40 ms at 50 MHz); 0 disables the watchdog
CTR_SIZE, 21, watchdog counter width; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req0, req1  in  1 each  level request; requester holds it high for its whole I2C transaction
gnt0, gnt1  out  1 each  grant, one-hot or zero
ena0/ena1, rw0/rw1, start_transfer0/1, stop_transfer0/1, r_start0/1  in  1 each  per-requester driver commands
data_wr0, data_wr1  in  8 each  per-requester write byte
data_rd0, data_rd1  out  8 each  read byte returned to each requester
busy0/busy1, ready0/ready1, ack_err0/ack_err1  out  1 each  per-requester driver status
drv_ena, drv_rw, drv_start_transfer, drv_stop_transfer, drv_r_start  out  1 each  to shared driver
drv_data_wr  out  8  to shared driver
drv_data_rd  in  8  from shared driver
drv_busy, drv_ready, drv_ack_err  in  1 each  from shared driver
timeout  out  1  one-cycle pulse when the watchdog revokes a grant

Behaviour:
Reset values:
- state=IDLE; gnt0=gnt1=0; last=1, so req0 wins the first tie; watchdog counter=0; timeout=0.
- All drv_* command outputs=0; data_rd0/1=0.

FSM states: IDLE, GRANT0, GRANT1, RELEASE.
- IDLE: if only one req is high, go to that GRANTn. If both are high, go to GRANTn for n != last. gnt rises the cycle after the req is sampled (1-cycle latency). Set last=n on entry.
- GRANTn: drv_* commands = requester n's inputs (combinational mux). The other requester's commands are ignored.
- GRANTn exit on req_n==0: go to RELEASE.
- GRANTn exit on watchdog expiry (counter==TIMEOUT_CYCLES-1): go to RELEASE and pulse timeout for 1 cycle.
- RELEASE: gnt=0; all drv_* commands forced 0. Stay until drv_busy==0 && drv_ready==1, then go to IDLE. A re-arbitration cycle is always spent in IDLE.

Status routing:
- Granted requester: busy/ready/ack_err/data_rd follow drv_* combinationally.
- Non-granted requester, and both requesters in IDLE/RELEASE: busy=1, ready=0, ack_err=0, data_rd holds its last value.

Watchdog:
- Counter clears on entry to any GRANTn and increments each cycle in GRANTn.
- Saturates and is ignored when TIMEOUT_CYCLES==0.

Boundary conditions:
- req_n drops and rises again while in GRANTn or RELEASE: the bus is still released. The new request competes in IDLE.
- A revoked requester keeps its req high: it is not re-granted until it drops req for at least 1 cycle. Track this with a per-requester "revoked" flag, cleared when that req is low.
- Both reqs high continuously: grants alternate 0,1,0,1.
- rst asserted mid-transaction: everything returns to reset values next edge. drv_ena=0 immediately, since outputs are registered-state based. Driver recovery is the driver's own rst.
- Requester-side ena without gnt has no effect on the bus.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2, RELEASE=2'd3) and the default TIMEOUT_CYCLES.
- Natural sub-module: i2c_cmd_mux, a purely combinational mux of the command and status buses selected by a 2-bit grant vector.
- Arbiter FSM and watchdog stay in the top block.

Test Plan:
- req0 pulses high for 50 cycles, drv model busy 30 cycles -> gnt0 at cycle+1; drv_ena mirrors ena0; after req0 falls, RELEASE until drv_busy=0, then IDLE; gnt1 never asserts.
- req0 and req1 rise on the same cycle after reset -> gnt0 first; after its release, gnt1; both held continuously -> strict alternation over 4 grants.
- During gnt0, drive ena1=1, data_wr1=8'hA5 -> drv_data_wr stays equal to data_wr0; busy1=1, ready1=0; data_rd1 unchanged.
- TIMEOUT_CYCLES=100, req1 held forever -> timeout pulses exactly at grant-cycle 100; gnt1 falls; req0 (pending) is granted after RELEASE; req1 is not re-granted until it drops low.
- Assert rst during GRANT1 with drv_busy=1 -> next cycle gnt1=0, drv_ena=0, state IDLE, timeout=0.
- drv_ack_err pulses during GRANT0 -> ack_err0 pulses the same cycle; ack_err1 stays 0.
